// File: rtl/playfield_pkg.sv
// Shared definitions for the Tetris playfield store.
// Holds the playfield FSM state encoding, the empty-cell constant and the
// default grid geometry used by the playfield, the renderer and the game FSM.
package playfield_pkg;

    localparam int DEF_ROWS   = 20;
    localparam int DEF_COLS   = 10;
    localparam int DEF_CELL_W = 3;

    localparam logic [DEF_CELL_W-1:0] EMPTY_CELL = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } pf_state_t;

endpackage

// File: rtl/row_full_detect.sv
// Combinational full-row detector.
// A row is full when every one of its COLS cells holds a nonzero colour code.
// Ports:
//   row_cells  in  COLS*CELL_W  packed row, cell c at [c*CELL_W +: CELL_W]
//   row_full   out 1            1 when every cell is occupied
module row_full_detect
    import playfield_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int CELL_W = DEF_CELL_W
) (
    input  logic [COLS*CELL_W-1:0] row_cells,
    output logic                   row_full
);

    logic [COLS-1:0] occupied_s;

    // OR-reduce each cell to an occupancy bit, then AND across the row
    always_comb begin
        occupied_s = '0;
        for (int c = 0; c < COLS; c++) begin
            occupied_s[c] = |row_cells[c*CELL_W +: CELL_W];
        end
        row_full = &occupied_s;
    end

endmodule

// File: rtl/tetris_playfield.sv
// Tetris playfield store with piece locking and a sequential line-clear engine.
// A locked tetromino (4 cells) is accepted in IDLE; the engine then scans
// bottom-up, and every full row is removed by copying the rows above it down
// one row per cycle. The same row index is re-checked after each removal.
// Ports:
//   clk, reset            clock, async active-high reset (grid and FSM)
//   rd_row/rd_col/rd_data combinational display read; 0 when out of range
//   lock_valid/lock_ready lock handshake (ready only in IDLE)
//   lock_rows/lock_cols   four cell coordinates, cell i at [i*W +: W]
//   lock_color            colour written to all four cells
//   clear_all             wipe the grid (IDLE only, a lock takes priority)
//   busy                  high in any state other than IDLE
//   done/lines_cleared    registered end-of-pass pulse and cleared-row count
module tetris_playfield
    import playfield_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int CELL_W = DEF_CELL_W,
    parameter int ROW_W  = $clog2(ROWS),
    parameter int COL_W  = $clog2(COLS),
    parameter int CNT_W  = $clog2(ROWS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROW_W-1:0]     rd_row,
    input  logic [COL_W-1:0]     rd_col,
    output logic [CELL_W-1:0]    rd_data,
    input  logic                 lock_valid,
    output logic                 lock_ready,
    input  logic [4*ROW_W-1:0]   lock_rows,
    input  logic [4*COL_W-1:0]   lock_cols,
    input  logic [CELL_W-1:0]    lock_color,
    input  logic                 clear_all,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     lines_cleared
);

    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(ROWS);
    localparam logic [CELL_W-1:0] EMPTY    = CELL_W'(EMPTY_CELL);

    logic [CELL_W-1:0]      grid_r [ROWS][COLS];
    pf_state_t              state_r, state_s;
    logic [ROW_W-1:0]       scan_row_r, scan_row_s;
    logic [ROW_W-1:0]       shift_row_r, shift_row_s;
    logic [CNT_W-1:0]       count_r, count_s;
    logic [CNT_W-1:0]       lines_r;
    logic                   done_r;
    logic [COLS*CELL_W-1:0] scan_cells_s;
    logic                   row_full_s;
    logic [ROW_W-1:0]       lk_row_s [4];
    logic [COL_W-1:0]       lk_col_s [4];
    logic [3:0]             lk_ok_s;

    // Unpack the four lock coordinates and flag the ones inside the grid
    always_comb begin
        lk_ok_s = 4'd0;
        for (int i = 0; i < 4; i++) begin
            lk_row_s[i] = lock_rows[i*ROW_W +: ROW_W];
            lk_col_s[i] = lock_cols[i*COL_W +: COL_W];
            lk_ok_s[i]  = (lk_row_s[i] <= LAST_ROW) && (lk_col_s[i] <= LAST_COL);
        end
    end

    // Gather the row under scan into a packed vector for the detector
    always_comb begin
        scan_cells_s = '0;
        for (int c = 0; c < COLS; c++) begin
            scan_cells_s[c*CELL_W +: CELL_W] = grid_r[scan_row_r][c];
        end
    end

    row_full_detect #(
        .COLS   (COLS),
        .CELL_W (CELL_W)
    ) u_row_full (
        .row_cells (scan_cells_s),
        .row_full  (row_full_s)
    );

    // Display read port; coordinates outside the grid read as empty
    always_comb begin
        if ((rd_row <= LAST_ROW) && (rd_col <= LAST_COL)) begin
            rd_data = grid_r[rd_row][rd_col];
        end else begin
            rd_data = EMPTY;
        end
    end

    // Next-state and scan/shift/count datapath decisions
    always_comb begin
        state_s     = state_r;
        scan_row_s  = scan_row_r;
        shift_row_s = shift_row_r;
        count_s     = count_r;
        case (state_r)
            IDLE: begin
                if (lock_valid) begin
                    state_s    = SCAN;
                    scan_row_s = LAST_ROW;
                    count_s    = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (row_full_s) begin
                    shift_row_s = scan_row_r;
                    state_s     = SHIFT;
                end else if (scan_row_r == '0) begin
                    state_s = DONE;
                end else begin
                    scan_row_s = scan_row_r - ROW_W'(1);
                end
            end
            SHIFT: begin
                if (shift_row_r != '0) begin
                    shift_row_s = shift_row_r - ROW_W'(1);
                end else begin
                    // scan_row is left alone so the row that just moved in is re-checked
                    state_s = SCAN;
                    if (count_r != CNT_MAX) begin
                        count_s = count_r + CNT_W'(1);
                    end else begin
                        count_s = count_r;
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, scan pointers, count and registered done/lines outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            scan_row_r  <= LAST_ROW;
            shift_row_r <= '0;
            count_r     <= '0;
            lines_r     <= '0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            scan_row_r  <= scan_row_s;
            shift_row_r <= shift_row_s;
            count_r     <= count_s;
            done_r      <= (state_s == DONE);
            if (state_s == DONE) begin
                lines_r <= count_r;
            end
        end
    end

    // Grid storage: lock writes and wipes in IDLE, one row copy per SHIFT cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    grid_r[r][c] <= EMPTY;
                end
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (lock_valid) begin
                        for (int i = 0; i < 4; i++) begin
                            if (lk_ok_s[i]) begin
                                grid_r[lk_row_s[i]][lk_col_s[i]] <= lock_color;
                            end
                        end
                    end else if (clear_all) begin
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < COLS; c++) begin
                                grid_r[r][c] <= EMPTY;
                            end
                        end
                    end
                end
                SHIFT: begin
                    for (int c = 0; c < COLS; c++) begin
                        if (shift_row_r != '0) begin
                            grid_r[shift_row_r][c] <= grid_r[shift_row_r - ROW_W'(1)][c];
                        end else begin
                            grid_r[0][c] <= EMPTY;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign lock_ready    = (state_r == IDLE);
    assign busy          = (state_r != IDLE);
    assign done          = done_r;
    assign lines_cleared = lines_r;

endmodule
